// File: rtl/gpo_pad_sequencer.sv
// General-purpose output pad sequencer: drains the pad, applies a new drive
// configuration, then gates output enable on pad bias readiness with a timeout fallback.

module gpo_pad_sequencer #(
    parameter int unsigned SETTLE_CYC   = 4,
    parameter int unsigned BIAS_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_oe,
    input  logic [1:0] cfg_ds,
    input  logic       cfg_sr,
    input  logic       cfg_co,
    input  logic [1:0] cfg_mode,
    input  logic       data,
    input  logic       vbias_ok,
    output logic       pad_do,
    output logic       pad_oe,
    output logic [1:0] pad_ds,
    output logic       pad_sr,
    output logic       pad_co,
    output logic       pad_odp,
    output logic       pad_odn,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_APPLY     = 3'd2,
        ST_WAIT_BIAS = 3'd3,
        ST_ACTIVE    = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] BIAS_LAST   = 8'(BIAS_TIMEOUT);

    // Returns {odp, odn}; the reserved mode leaves both open-drive controls off.
    function automatic logic [1:0] mode_to_od(input logic [1:0] mode);
        logic [1:0] od;
        case (mode)
            2'b00:   od = 2'b00;
            2'b01:   od = 2'b10;
            2'b10:   od = 2'b01;
            default: od = 2'b00;
        endcase
        return od;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] settle_cnt_r;
    logic [7:0] bias_cnt_r;
    logic       shd_oe_r;
    logic [1:0] shd_ds_r;
    logic       shd_sr_r;
    logic       shd_co_r;
    logic [1:0] shd_mode_r;
    logic       cfg_ready_r;
    logic       busy_r;
    logic       err_r;
    logic       pad_do_r;
    logic       pad_oe_r;
    logic [1:0] pad_ds_r;
    logic       pad_sr_r;
    logic       pad_co_r;
    logic       pad_odp_r;
    logic       pad_odn_r;
    logic       accept_s;
    logic       timeout_s;
    logic       load_pads_s;

    assign accept_s = cfg_valid & cfg_ready_r;

    // Next-state decode; an accepted request outranks bias loss in ACTIVE.
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        load_pads_s = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (accept_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            ST_DRAIN: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_APPLY;
                    load_pads_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_APPLY: begin
                if (!shd_oe_r) begin
                    state_nxt_s = ST_OFF;
                end else if ((pad_ds_r == 2'b00) || vbias_ok) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_WAIT_BIAS;
                end
            end
            ST_WAIT_BIAS: begin
                if (vbias_ok) begin
                    state_nxt_s = ST_ACTIVE;
                end else if (bias_cnt_r == BIAS_LAST) begin
                    state_nxt_s = ST_ACTIVE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_BIAS;
                end
            end
            ST_ACTIVE: begin
                if (accept_s) begin
                    state_nxt_s = ST_DRAIN;
                end else if ((pad_ds_r != 2'b00) && !vbias_ok) begin
                    state_nxt_s = ST_WAIT_BIAS;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
            end
        endcase
    end

    // State register and status outputs, all registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_OFF;
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            pad_oe_r    <= 1'b0;
            pad_do_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cfg_ready_r <= (state_nxt_s == ST_OFF) || (state_nxt_s == ST_ACTIVE);
            busy_r      <= (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_APPLY) ||
                           (state_nxt_s == ST_WAIT_BIAS);
            pad_oe_r    <= (state_nxt_s == ST_ACTIVE);
            pad_do_r    <= data;
            if (accept_s) begin
                err_r <= 1'b0;
            end else if (timeout_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Drain and bias-wait counters; both restart from zero on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt_r <= 8'd0;
            bias_cnt_r   <= 8'd0;
        end else begin
            if (state_r == ST_DRAIN) begin
                settle_cnt_r <= settle_cnt_r + 8'd1;
            end else begin
                settle_cnt_r <= 8'd0;
            end
            if ((state_r == ST_WAIT_BIAS) && (state_nxt_s == ST_WAIT_BIAS)) begin
                bias_cnt_r <= bias_cnt_r + 8'd1;
            end else begin
                bias_cnt_r <= 8'd0;
            end
        end
    end

    // Shadow copy of the accepted request; reserved mode never enables the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_oe_r   <= 1'b0;
            shd_ds_r   <= 2'b00;
            shd_sr_r   <= 1'b0;
            shd_co_r   <= 1'b0;
            shd_mode_r <= 2'b00;
        end else if (accept_s) begin
            shd_oe_r   <= cfg_oe & (cfg_mode != 2'b11);
            shd_ds_r   <= cfg_ds;
            shd_sr_r   <= cfg_sr;
            shd_co_r   <= cfg_co;
            shd_mode_r <= cfg_mode;
        end else begin
            shd_oe_r   <= shd_oe_r;
            shd_ds_r   <= shd_ds_r;
            shd_sr_r   <= shd_sr_r;
            shd_co_r   <= shd_co_r;
            shd_mode_r <= shd_mode_r;
        end
    end

    // Pad controls move only on the way into APPLY or on a bias-timeout fallback.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_ds_r  <= 2'b00;
            pad_sr_r  <= 1'b0;
            pad_co_r  <= 1'b0;
            pad_odp_r <= 1'b0;
            pad_odn_r <= 1'b0;
        end else if (load_pads_s) begin
            pad_ds_r               <= shd_ds_r;
            pad_sr_r               <= shd_sr_r;
            pad_co_r               <= shd_co_r;
            {pad_odp_r, pad_odn_r} <= mode_to_od(shd_mode_r);
        end else if (timeout_s) begin
            pad_ds_r <= 2'b00;
        end else begin
            pad_ds_r  <= pad_ds_r;
            pad_sr_r  <= pad_sr_r;
            pad_co_r  <= pad_co_r;
            pad_odp_r <= pad_odp_r;
            pad_odn_r <= pad_odn_r;
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign pad_do    = pad_do_r;
    assign pad_oe    = pad_oe_r;
    assign pad_ds    = pad_ds_r;
    assign pad_sr    = pad_sr_r;
    assign pad_co    = pad_co_r;
    assign pad_odp   = pad_odp_r;
    assign pad_odn   = pad_odn_r;

endmodule
